// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Drives one shared BCD decoder across NUM_DIGITS digit positions. Each
// slot drives one digit, then optionally blanks all digits for a dead-time
// gap. New digit values are loaded into a shadow buffer through a valid/ready
// handshake and swapped into the displayed set only at frame boundaries, so
// a number never shows half old and half new digits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_blank,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  // With no gap the GAP state is unreachable; the value only keeps widths sane.
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [3:0]       CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DRIVE,
    ST_GAP
  } state_t;

  // Scan state
  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    boundary;

  // Digit buffers and handshake
  logic [4*NUM_DIGITS-1:0] active_reg, active_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg, shadow_next;
  logic                    pending_reg, pending_next;
  logic                    load_ready_reg;
  logic                    commit;
  logic                    xfer;

  // Output pipeline
  logic [3:0]              bcd_reg, bcd_next;
  logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
  logic                    frame_start_reg;

  // Leading-zero decode, computed on the post-commit digit set
  logic [NUM_DIGITS-1:0]   digit_zero;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              disp_code [NUM_DIGITS];

  logic [IDX_W-1:0]        idx_inc;

  assign idx_inc = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);

  // Scan sequencer: next state, slot index, cycle counter and frame boundary
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    boundary   = 1'b0;
    if (!enable) begin
      state_next = ST_OFF;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_DRIVE;
          idx_next   = '0;
          cnt_next   = '0;
          boundary   = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_reg == DRIVE_LAST) begin
            cnt_next = '0;
            if (GAP_CYCLES > 0) begin
              state_next = ST_GAP;
            end else begin
              state_next = ST_DRIVE;
              idx_next   = idx_inc;
              boundary   = (idx_inc == '0);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = ST_DRIVE;
            idx_next   = idx_inc;
            cnt_next   = '0;
            boundary   = (idx_inc == '0);
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_OFF;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Double buffer: commit uses the pre-edge pending flag, so a load landing on
  // a boundary edge waits for the following frame
  always_comb begin
    commit       = boundary && pending_reg;
    xfer         = load_valid && !pending_reg;
    active_next  = commit ? shadow_reg : active_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    if (commit) begin
      pending_next = 1'b0;
    end else if (xfer) begin
      shadow_next  = load_data;
      pending_next = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_zero[gi]    = (active_next[4*gi +: 4] == 4'h0);
      // One-hot digit select for the slot being entered
      assign digit_en_next[gi] = (state_next == ST_DRIVE) && (idx_next == IDX_W'(gi));
    end
  endgenerate

  // Leading-zero blanking: a digit is blank when it and every more
  // significant digit are zero; digit 0 always shows
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run && digit_zero[i];
      upper_zero[i] = run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lz_blank && (i > 0) && upper_zero[i]) begin
        disp_code[i] = CODE_BLANK;
      end else begin
        disp_code[i] = active_next[4*i +: 4];
      end
    end
  end

  // Code presented to the shared decoder in the slot being entered
  always_comb begin
    bcd_next = CODE_BLANK;
    if (state_next == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_next == IDX_W'(i)) begin
          bcd_next = disp_code[i];
        end
      end
    end
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_OFF;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      active_reg      <= '1;
      shadow_reg      <= '0;
      pending_reg     <= 1'b0;
      load_ready_reg  <= 1'b1;
      bcd_reg         <= CODE_BLANK;
      digit_en_reg    <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      active_reg      <= active_next;
      shadow_reg      <= shadow_next;
      pending_reg     <= pending_next;
      load_ready_reg  <= !pending_next;
      bcd_reg         <= bcd_next;
      digit_en_reg    <= digit_en_next;
      frame_start_reg <= boundary;
    end
  end

  assign load_ready  = load_ready_reg;
  assign bcd_out     = bcd_reg;
  assign digit_en    = digit_en_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one external combinational BCD-to-seven-segment decoder across NUM_DIGITS common-anode/cathode digit positions. It holds a double-buffered set of BCD digits loaded through a valid/ready handshake. Each scan slot drives one digit's code to the shared decoder, asserts that digit's enable, then inserts a dead-time gap against ghosting. Shadow data commits atomically at frame boundaries so a displayed number never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DRIVE_CYCLES, 1000, clock cycles each digit is driven (>=1)
GAP_CYCLES, 2, dead-time cycles with all digits off between slots (>=0; 0 = no gap state)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scanning; 0 = display off
lz_blank  in  1  1 = suppress leading zeros
load_valid  in  1  load_data valid
load_ready  out  1  shadow buffer free; transfer when load_valid&&load_ready at a rising edge
load_data  in  4*NUM_DIGITS  packed BCD, digit i = bits [4i+3:4i], digit 0 least significant
bcd_out  out  4  code to shared decoder; 4'hF = blank (decoder default lights nothing)
digit_en  out  NUM_DIGITS  one-hot digit select, active-high
frame_start  out  1  one-cycle pulse in first DRIVE cycle of digit 0

Behaviour:
- All outputs registered; all state changes on the rising clk edge; rst synchronous, active-high, overrides everything.
- Reset values: state OFF, scan index 0, cycle counter 0, active digits all 4'hF, shadow 0, pending 0. Outputs: load_ready=1, bcd_out=4'hF, digit_en=0, frame_start=0.
- States: OFF, DRIVE, GAP.
- OFF: digit_en=0, bcd_out=4'hF. If enable is sampled 1, the next state is DRIVE with index 0.
- DRIVE: digit_en has only bit[index] set, and bcd_out carries the displayed code for that index. The state lasts exactly DRIVE_CYCLES cycles. It then moves to GAP, or directly to DRIVE of the next index when GAP_CYCLES=0.
- GAP: digit_en=0, bcd_out=4'hF, lasting exactly GAP_CYCLES cycles. It then moves to DRIVE of the next index.
- Index advances 0,1,..,NUM_DIGITS-1 and wraps to 0. Frame length is NUM_DIGITS*(DRIVE_CYCLES+GAP_CYCLES) cycles.
- Frame boundary: every entry into DRIVE index 0, whether from OFF, GAP or DRIVE. frame_start=1 for that first cycle only.
- enable sampled 0 in any state: next state OFF, index and counter cleared. Pending shadow data is retained.
- Handshake: load_ready = !pending. On a transfer, shadow <= load_data and pending <= 1. While pending=1, further load_data is ignored and shadow is not overwritten.
- Commit: on the edge entering a frame boundary with pending=1, active <= shadow and pending <= 0. The bcd_out of that same first cycle already reflects the new values, and load_ready returns to 1 in that cycle.
- Simultaneous transfer and boundary edge: the commit uses the pre-edge pending value. With pending=0 the new data lands in shadow and commits at the next boundary. With pending=1 load_ready was 0, so no transfer occurs.
- Displayed code for index i: 4'hF when lz_blank=1, i>0, and active digits i..NUM_DIGITS-1 are all 4'h0. Otherwise it is active[i]. Digit 0 is never zero-blanked.
- Codes 4'hA..4'hF are passed through unchanged; the decoder blanks them.
- lz_blank is sampled continuously and takes effect on the next DRIVE cycle.
- rst mid-frame: returns to OFF in the next cycle, discards active and shadow, and digits show blank until the first commit.

Test Plan:
- Params 4/4/1. rst, enable=1, load 16'h0123 in the first cycle. The first frame shows all 4'hF (transfer arrives after boundary). From the second frame_start: digit_en 0001/0010/0100/1000 with bcd_out 3,2,1,0, each for 4 cycles, each followed by 1 gap cycle (digit_en=0). frame_start period is 20 cycles.
- lz_blank=1, active 16'h0007. bcd_out is 7,F,F,F. Active 16'h0000 gives 0,F,F,F. Active 16'h1000 gives 0,0,0,1.
- Load 16'h1111, then assert load_valid with 16'h2222 while load_ready=0. It is ignored: the next frame shows 1111, and load_ready rises in that frame's first cycle.
- Transfer 16'h4321 on the exact edge entering DRIVE index 0 with pending=0. The current frame keeps old values, 4321 appears one frame later, and load_ready=0 in between.
- GAP_CYCLES=0, DRIVE_CYCLES=1. digit_en steps 0001,0010,0100,1000 on consecutive cycles with no zero cycle, and frame_start is pulsed every 4 cycles.
- Drop enable mid-slot at index 2. digit_en=0 next cycle. Re-enable: DRIVE resumes at index 0 with frame_start=1. Assert rst mid-frame: all outputs return to reset values on the next cycle.
